// File: rtl/fifo_share_pkg.sv
// rtl/fifo_share_pkg.sv - shared types and width helpers for the FIFO share arbiter
package fifo_share_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational first-set search starting at a rotating pointer
module rr_priority_pick
   import fifo_share_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = id_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  start,
   output logic             found,
   output logic [ID_W-1:0]  idx
);

   logic [ID_W:0] cand;

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int off = N_REQ - 1; off >= 0; off--) begin
         cand = {1'b0, start} + (ID_W + 1)'(off);
         if (cand >= (ID_W + 1)'(N_REQ)) begin
            cand = cand - (ID_W + 1)'(N_REQ);
         end
         if (req[cand[ID_W-1:0]]) begin
            found = 1'b1;
            idx   = cand[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_share_arbiter.sv
// rtl/fifo_share_arbiter.sv - round-robin burst arbiter sharing one FIFO upstream port
module fifo_share_arbiter
   import fifo_share_pkg::*;
#(
   parameter int D_WIDTH   = 6,
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*D_WIDTH-1:0]   req_data,
   output logic                       up_valid,
   input  logic                       up_ready,
   output logic [D_WIDTH-1:0]         up_data,
   output logic [$clog2(N_REQ)-1:0]   up_src,
   output logic                       busy
);

   localparam int ID_W  = id_width(N_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   state_t             state, state_n;
   logic [ID_W-1:0]    rr_ptr, rr_ptr_n;
   logic [ID_W-1:0]    grant_id, grant_id_n;
   logic [CNT_W-1:0]   burst_cnt, burst_cnt_n;
   logic [ID_W-1:0]    next_id;
   logic [ID_W-1:0]    pick_idx;
   logic               pick_found;
   logic               grant_valid;
   logic               beat;
   logic               last_beat;
   logic [D_WIDTH-1:0] data_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign data_arr[g] = req_data[g*D_WIDTH +: D_WIDTH];
   end

   rr_priority_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req   (req_valid),
      .start (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign grant_valid = req_valid[grant_id];
   assign next_id     = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
   assign beat        = (state == BUSY) && !rst && grant_valid && up_ready;
   assign last_beat   = (burst_cnt == CNT_W'(MAX_BURST - 1));
   assign up_src      = grant_id;
   assign busy        = (state == BUSY);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_id  <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_n;
         rr_ptr    <= rr_ptr_n;
         grant_id  <= grant_id_n;
         burst_cnt <= burst_cnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      rr_ptr_n    = rr_ptr;
      grant_id_n  = grant_id;
      burst_cnt_n = burst_cnt;
      up_valid    = 1'b0;
      req_ready   = '0;
      up_data     = '0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               grant_id_n  = pick_idx;
               burst_cnt_n = '0;
               state_n     = BUSY;
            end
         end
         BUSY: begin
            up_data = data_arr[grant_id];
            // Handshake is masked during reset so no beat slips through that cycle.
            if (!rst) begin
               up_valid            = grant_valid;
               req_ready[grant_id] = up_ready;
            end
            if (beat) begin
               burst_cnt_n = burst_cnt + 1'b1;
               if (last_beat) begin
                  state_n  = IDLE;
                  rr_ptr_n = next_id;
               end
            end else if (!grant_valid) begin
               state_n  = IDLE;
               rr_ptr_n = next_id;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
